// File: rtl/vga_sync_if.sv
// Timing bundle from the VGA sync generator to the pixel generator.
// The master drives the sync pins and scan position; the slave consumes them.
interface vga_sync_if;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_tick;

  modport master (
    output p_tick, x, y, video_on, hsync, vsync, frame_tick
  );

  modport slave (
    input p_tick, x, y, video_on, hsync, vsync, frame_tick
  );
endinterface

// File: rtl/vga_sync.sv
// 640x480@60 VGA timing generator: clock divider to a pixel tick, horizontal and
// vertical scan counters, registered active-low syncs and frame/video decodes.
module vga_sync #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vga
);

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned DIV_W    = $clog2(CLK_DIV);
  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_FIRST = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_LAST  = H_DISPLAY + H_FRONT + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_LAST  = V_DISPLAY + V_FRONT + V_SYNC - 1;

  logic [DIV_W-1:0] div_reg;
  logic [CNT_W-1:0] x_reg;
  logic [CNT_W-1:0] y_reg;
  logic [CNT_W-1:0] x_next;
  logic [CNT_W-1:0] y_next;
  logic             hsync_reg;
  logic             vsync_reg;
  logic             p_tick_c;
  logic             x_last_c;
  logic             y_last_c;

  assign p_tick_c = (div_reg == DIV_W'(CLK_DIV - 1));
  assign x_last_c = (x_reg == CNT_W'(H_TOTAL - 1));
  assign y_last_c = (y_reg == CNT_W'(V_TOTAL - 1));

  // Next scan position; syncs are decoded from it so they line up with X/Y.
  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (p_tick_c) begin
      if (x_last_c) begin
        x_next = '0;
        y_next = y_last_c ? '0 : y_reg + CNT_W'(1);
      end else begin
        x_next = x_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg   <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      hsync_reg <= 1'b1;
      vsync_reg <= 1'b1;
    end else begin
      div_reg   <= p_tick_c ? '0 : div_reg + DIV_W'(1);
      x_reg     <= x_next;
      y_reg     <= y_next;
      hsync_reg <= ~((x_next >= CNT_W'(HS_FIRST)) && (x_next <= CNT_W'(HS_LAST)));
      vsync_reg <= ~((y_next >= CNT_W'(VS_FIRST)) && (y_next <= CNT_W'(VS_LAST)));
    end
  end

  assign vga.p_tick     = p_tick_c;
  assign vga.x          = x_reg;
  assign vga.y          = y_reg;
  assign vga.video_on   = (x_reg < CNT_W'(H_DISPLAY)) && (y_reg < CNT_W'(V_DISPLAY));
  assign vga.hsync      = hsync_reg;
  assign vga.vsync      = vsync_reg;
  assign vga.frame_tick = p_tick_c & x_last_c & y_last_c;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: default, CLK_DIV=2 and a shrunken-frame instance checked
// cycle by cycle against a position-from-elapsed-clocks reference model.
module tb_vga_sync;

  typedef struct packed {
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_tick;
  } obs_t;

  localparam obs_t RST_OBS = '{p_tick: 1'b0, x: 10'd0, y: 10'd0, video_on: 1'b1,
                               hsync: 1'b1, vsync: 1'b1, frame_tick: 1'b0};

  // Shrunken instance: 17 pixels x 13 lines, 3 clocks per pixel
  localparam int C_D = 3, C_HD = 10, C_HF = 2, C_HS = 3, C_HB = 2;
  localparam int C_VD = 6, C_VF = 2, C_VS = 2, C_VB = 3;
  localparam int C_HT = C_HD + C_HF + C_HS + C_HB;
  localparam int C_VT = C_VD + C_VF + C_VS + C_VB;
  localparam int C_FRAME = C_HT * C_VT * C_D;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  longint n_a = 0, n_b = 0, n_c = 0;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  vga_sync_if vif_a ();
  vga_sync_if vif_b ();
  vga_sync_if vif_c ();

  vga_sync #(.CLK_DIV(4)) dut_a (.clk(clk), .reset(rst_a), .vga(vif_a));
  vga_sync #(.CLK_DIV(2)) dut_b (.clk(clk), .reset(rst_b), .vga(vif_b));
  vga_sync #(.CLK_DIV(C_D), .H_DISPLAY(C_HD), .H_FRONT(C_HF), .H_SYNC(C_HS), .H_BACK(C_HB),
             .V_DISPLAY(C_VD), .V_FRONT(C_VF), .V_SYNC(C_VS), .V_BACK(C_VB))
    dut_c (.clk(clk), .reset(rst_c), .vga(vif_c));

  // Clocks elapsed since each instance last left reset
  always @(posedge clk) begin
    n_a <= rst_a ? 64'sd0 : n_a + 64'sd1;
    n_b <= rst_b ? 64'sd0 : n_b + 64'sd1;
    n_c <= rst_c ? 64'sd0 : n_c + 64'sd1;
  end

  // Expected outputs after n free-running clocks, straight from the timing rules
  function automatic obs_t model(longint n, int d, int hd, int hf, int hs, int hb,
                                 int vd, int vf, int vs, int vb);
    obs_t o;
    int ht, vt, x, y;
    longint pix;
    ht  = hd + hf + hs + hb;
    vt  = vd + vf + vs + vb;
    pix = n / longint'(d);
    x   = int'(pix % longint'(ht));
    y   = int'((pix / longint'(ht)) % longint'(vt));
    o.p_tick     = (n % longint'(d)) == longint'(d - 1);
    o.x          = 10'(x);
    o.y          = 10'(y);
    o.video_on   = (x < hd) && (y < vd);
    o.hsync      = !((x >= hd + hf) && (x < hd + hf + hs));
    o.vsync      = !((y >= vd + vf) && (y < vd + vf + vs));
    o.frame_tick = o.p_tick && (x == ht - 1) && (y == vt - 1);
    return o;
  endfunction

  function automatic obs_t model_a(longint n);
    return model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction
  function automatic obs_t model_b(longint n);
    return model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction
  function automatic obs_t model_c(longint n);
    return model(n, C_D, C_HD, C_HF, C_HS, C_HB, C_VD, C_VF, C_VS, C_VB);
  endfunction

  function automatic obs_t obs_a();
    return '{vif_a.p_tick, vif_a.x, vif_a.y, vif_a.video_on, vif_a.hsync, vif_a.vsync, vif_a.frame_tick};
  endfunction
  function automatic obs_t obs_b();
    return '{vif_b.p_tick, vif_b.x, vif_b.y, vif_b.video_on, vif_b.hsync, vif_b.vsync, vif_b.frame_tick};
  endfunction
  function automatic obs_t obs_c();
    return '{vif_c.p_tick, vif_c.x, vif_c.y, vif_c.video_on, vif_c.hsync, vif_c.vsync, vif_c.frame_tick};
  endfunction

  task automatic test_reset();
    obs_t o;
    logic exp_pt [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int   exp_x  [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = obs_a();
      checks++;
      if (o !== RST_OBS) $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, o, RST_OBS);
      else passed++;
    end
    rst_a = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      o = obs_a();
      checks++;
      if (o.p_tick !== exp_pt[k] || o.x !== 10'(exp_x[k]) || o.y !== 10'd0)
        $display("FAIL release_seq k=%0d got p_tick=%b x=%0d y=%0d exp p_tick=%b x=%0d y=0",
                 k, o.p_tick, o.x, o.y, exp_pt[k], exp_x[k]);
      else passed++;
    end
  endtask

  task automatic test_line();
    obs_t o, e;
    int hlow = 0, voff = 0, ticks = 0;
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    for (int k = 0; k <= 3200; k++) begin
      if (k > 0) @(negedge clk);
      o = obs_a();
      e = model_a(n_a);
      checks++;
      if (o !== e) $display("FAIL line_cycle n=%0d got=%h exp=%h", n_a, o, e);
      else passed++;
      if (k < 3200) begin
        hlow  += (o.hsync == 1'b0) ? 1 : 0;
        voff  += (o.video_on == 1'b0) ? 1 : 0;
        ticks += (o.p_tick == 1'b1) ? 1 : 0;
      end
      if (k == 3200) begin
        checks++;
        if (o.x !== 10'd0 || o.y !== 10'd1)
          $display("FAIL line_wrap got x=%0d y=%0d exp x=0 y=1", o.x, o.y);
        else passed++;
      end
    end
    checks++;
    if (hlow != 384) $display("FAIL line_hsync_width got=%0d exp=384", hlow); else passed++;
    checks++;
    if (voff != 640) $display("FAIL line_blank_clocks got=%0d exp=640", voff); else passed++;
    checks++;
    if (ticks != 800) $display("FAIL line_pticks got=%0d exp=800", ticks); else passed++;
  endtask

  task automatic test_clk_div2();
    obs_t o, e;
    int hlow = 0, ticks = 0;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    for (int k = 0; k <= 1600; k++) begin
      if (k > 0) @(negedge clk);
      o = obs_b();
      e = model_b(n_b);
      checks++;
      if (o !== e) $display("FAIL div2_cycle n=%0d got=%h exp=%h", n_b, o, e);
      else passed++;
      if (k < 1600) begin
        hlow  += (o.hsync == 1'b0) ? 1 : 0;
        ticks += (o.p_tick == 1'b1) ? 1 : 0;
      end
    end
    checks++;
    if (hlow != 192) $display("FAIL div2_hsync_width got=%0d exp=192", hlow); else passed++;
    checks++;
    if (ticks != 800) $display("FAIL div2_pticks got=%0d exp=800", ticks); else passed++;
    checks++;
    if (o.x !== 10'd0 || o.y !== 10'd1)
      $display("FAIL div2_line_len got x=%0d y=%0d exp x=0 y=1", o.x, o.y);
    else passed++;
  endtask

  task automatic test_frame();
    obs_t o, e;
    int vlow = 0, vid_bad = 0, ft_cnt = 0, cons = 0;
    longint ft_first = -1, ft_second = -1, cons_first = -1, cons_last = -1;
    rst_c = 1'b1;
    repeat (2) @(negedge clk);
    rst_c = 1'b0;
    for (int k = 0; k <= 2 * C_FRAME; k++) begin
      if (k > 0) @(negedge clk);
      o = obs_c();
      e = model_c(n_c);
      checks++;
      if (o !== e) $display("FAIL frame_cycle n=%0d got=%h exp=%h", n_c, o, e);
      else passed++;
      if (o.frame_tick === 1'b1) begin
        ft_cnt++;
        if (ft_first < 0) ft_first = n_c; else ft_second = n_c;
      end
      if (k < C_FRAME) begin
        vlow    += (o.vsync == 1'b0) ? 1 : 0;
        vid_bad += (o.y >= 10'(C_VD) && o.video_on == 1'b1) ? 1 : 0;
        if (o.y == 10'(C_VD + 1) && o.x == 10'd0) begin
          cons++;
          if (cons_first < 0) cons_first = n_c;
          cons_last = n_c;
        end
      end
      if (k == C_FRAME) begin
        checks++;
        if (o.x !== 10'd0 || o.y !== 10'd0)
          $display("FAIL frame_wrap got x=%0d y=%0d exp x=0 y=0", o.x, o.y);
        else passed++;
      end
    end
    checks++;
    if (ft_cnt != 2 || ft_first != longint'(C_FRAME - 1))
      $display("FAIL frame_tick got count=%0d first=%0d exp count=2 first=%0d", ft_cnt, ft_first, C_FRAME - 1);
    else passed++;
    checks++;
    if (ft_second - ft_first != longint'(C_FRAME))
      $display("FAIL frame_length got=%0d exp=%0d", ft_second - ft_first, C_FRAME);
    else passed++;
    checks++;
    if (vlow != C_VS * C_HT * C_D) $display("FAIL frame_vsync_width got=%0d exp=%0d", vlow, C_VS * C_HT * C_D);
    else passed++;
    checks++;
    if (vid_bad != 0) $display("FAIL frame_video_blank got=%0d exp=0", vid_bad); else passed++;
    checks++;
    if (cons != C_D || cons_last - cons_first != longint'(C_D - 1))
      $display("FAIL consumer_tick got count=%0d span=%0d exp count=%0d span=%0d",
               cons, cons_last - cons_first, C_D, C_D - 1);
    else passed++;
  endtask

  task automatic test_mid_reset();
    obs_t o, e;
    int target;
    for (int it = 0; it < 5; it++) begin
      // First pass lands inside both syncs; the rest at random frame positions
      target = (it == 0) ? ((C_VD + C_VF + 1) * C_HT + (C_HD + C_HF + 1)) * C_D + 1
                         : int'($urandom_range(C_FRAME - 1, 1));
      rst_c = 1'b1;
      repeat (2) @(negedge clk);
      rst_c = 1'b0;
      while (n_c < longint'(target)) @(negedge clk);
      o = obs_c();
      e = model_c(n_c);
      checks++;
      if (o !== e) $display("FAIL midrst_pre n=%0d got=%h exp=%h", n_c, o, e);
      else passed++;
      if (it == 0) begin
        checks++;
        if (o.hsync !== 1'b0 || o.vsync !== 1'b0)
          $display("FAIL midrst_in_sync got hsync=%b vsync=%b exp 0 0", o.hsync, o.vsync);
        else passed++;
      end
      rst_c = 1'b1;
      @(negedge clk);
      o = obs_c();
      checks++;
      if (o !== RST_OBS) $display("FAIL midrst_forced got=%h exp=%h", o, RST_OBS);
      else passed++;
      rst_c = 1'b0;
      for (int k = 0; k < int'($urandom_range(120, 20)); k++) begin
        @(negedge clk);
        o = obs_c();
        e = model_c(n_c);
        checks++;
        if (o !== e) $display("FAIL midrst_resume n=%0d got=%h exp=%h", n_c, o, e);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_clk_div2();
    test_frame();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync.md
# vga_sync

Timing generator for the 640x480 @ 60 Hz VGA output. It divides the system clock down to a pixel-enable tick and runs the horizontal and vertical scan counters from that tick. It drives the HSYNC/VSYNC pins and supplies X, Y, VIDEO_ON and the pixel tick to the pixel generator, which uses them as its X, Y, VIDEO_ON and CE inputs.

## Interface
- CLK_DIV, 4: system clocks per pixel. 100 MHz / 4 = 25 MHz pixel rate. Legal range 2..16.
- H_DISPLAY, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_DISPLAY, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BACK, 33: vertical back porch, in lines.

Ports:
- CLK  in  1  system clock (100 MHz).
- RESET  in  1  synchronous, active-high reset.
- P_TICK  out  1  pixel enable; one-CLK pulse every CLK_DIV clocks.
- X  out  10  horizontal counter, 0..H_TOTAL-1, where H_TOTAL = sum of the four H_* parameters = 800.
- Y  out  10  vertical counter, 0..V_TOTAL-1, where V_TOTAL = sum of the four V_* parameters = 525.
- VIDEO_ON  out  1  high when X < H_DISPLAY and Y < V_DISPLAY.
- HSYNC  out  1  horizontal sync, active low, registered.
- VSYNC  out  1  vertical sync, active low, registered.
- FRAME_TICK  out  1  one-CLK pulse on the last pixel of each frame.

## Operation
**Divider**
- div_reg counts 0..CLK_DIV-1 every CLK and wraps to 0.
- P_TICK = (div_reg == CLK_DIV-1), combinational from the register.

**Horizontal counter (X)**
- X is the counter register itself.
- Advances only on cycles where P_TICK=1.
- Wraps from H_TOTAL-1 (799) to 0.

**Vertical counter (Y)**
- Y is the counter register itself.
- Advances only when P_TICK=1 and X=799.
- Wraps from V_TOTAL-1 (524) to 0.

**Derived outputs**
- VIDEO_ON is combinational from X and Y: (X<640) && (Y<480).
- HSYNC is registered from the next value of X: low exactly while X is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656, 751]. No lag relative to X.
- VSYNC is registered the same way from the next value of Y: low exactly while Y is in [490, 491].
- FRAME_TICK = P_TICK && X==799 && Y==524, combinational.
- Every count value 0..799 and 0..524 is visited, so the consumer's decode of Y==481 && X==0 is hit exactly once per frame, for CLK_DIV clocks.

**Width rules**
- Counters are 10 bits; 799 and 524 both fit.
- Wrap detection uses equality compare with the terminal count. Arithmetic overflow is never relied on.
- No output is ever X or undefined after the first reset cycle.

## Timing
**Reset values** (held for every cycle RESET=1):
- div_reg = 0, X = 0, Y = 0.
- HSYNC = 1, VSYNC = 1.
- P_TICK = 0, FRAME_TICK = 0.
- VIDEO_ON = 1, since X=Y=0.

**After reset release**
- div_reg takes the values 0, 1, 2, 3 on the first four clocks.
- P_TICK is high in the 4th clock after RESET falls.
- X becomes 1 at the following edge.

**Rates**
- Line period: 800 × CLK_DIV = 3200 CLK.
- Frame period: 420000 × CLK_DIV = 1,680,000 CLK, giving 59.52 Hz at 100 MHz.

**Pulse widths**
- HSYNC low for 96 × CLK_DIV = 384 CLK.
- VSYNC low for 2 × 800 × CLK_DIV = 6400 CLK.

**Timing relationships**
- X, Y, HSYNC and VSYNC are stable between P_TICK pulses. The consumer samples on P_TICK cycles.
- On the 799→0 wrap, X and Y update on the same edge.
- On the end-of-frame wrap, both counters return to 0 on the same edge, and FRAME_TICK is high in the cycle before that edge.

**Reset mid-line or mid-frame**
- The next edge forces all state to its reset values regardless of position.
- Sync outputs go inactive (high) immediately, with no partial-pulse completion.

## Test plan
- **Reset then run 8 CLK:** X=0, HSYNC=1, VSYNC=1 during reset. P_TICK high on the 4th clock after release only. X=1 from the 5th clock; X=2 after the 8th-clock P_TICK.
- **Run one full line (3200 CLK):**
  - X visits 0..799 once each, then returns to 0.
  - Y increments 0→1 on the same edge as the X wrap.
  - HSYNC falls when X becomes 656, rises when X becomes 752.
  - VIDEO_ON falls when X becomes 640.
- **Run one full frame:**
  - VSYNC low exactly while Y is 490..491.
  - VIDEO_ON is 0 for all Y ≥ 480.
  - Exactly one FRAME_TICK pulse, at X=799, Y=524.
  - Next edge gives X=0, Y=0.
  - Frame length is 1,680,000 CLK.
- **Consumer tick check:** count cycles with Y==481 && X==0 per frame; the count must be exactly CLK_DIV (4), all within one pixel slot.
- **Reset asserted at X=700, Y=491 (inside both syncs):** one edge later X=0, Y=0, HSYNC=1, VSYNC=1, div_reg=0. Normal sequence resumes on release.
- **CLK_DIV=2 instance:** P_TICK every 2nd CLK, line length 1600 CLK. HSYNC low for 192 CLK; sync positions in X unchanged.
